rx_packet_fifo: RTL and testbench

//   Sits directly downstream of the UART byte receiver and turns its byte/gap signalling into a

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rx_packet_fifo_sync_fifo.sv | 69 ++++++
 rtl/rx_packet_fifo.sv | 121 ++++++++++++
 tb/tb_rx_packet_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive path.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef struct packed {
      logic                   last;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   // Bit count needed to index `value` entries; usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_packet_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO with extra-MSB pointers and an occupancy level.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   output logic                  wr_accept,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] level
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             rd_fire;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      level = wr_ptr_q - rd_ptr_q;

      rd_fire   = rd_en && !empty;
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      wr_accept = wr_en && (!full || rd_fire);

      if (wr_accept) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; equal pointers mark it empty and rd_data is masked.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rx_packet_fifo.sv
// Frames UART receiver bytes into a packet stream: a one-byte hold stage tags the byte before
// an idle gap as last, a FIFO buffers entries, and packet/overflow bookkeeping sits alongside.
module rx_packet_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  rx_data_ready,
   input  logic                  rx_endofpacket,
   output logic                  m_valid,
   output logic [DATA_W-1:0]     m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic [clog2(DEPTH):0] level,
   output logic                  pkt_avail,
   output logic                  overflow,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int LVL_W = clog2(DEPTH) + 1;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [LVL_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   entry_t            push_entry;
   entry_t            head_entry;
   logic              push;
   logic              push_accept;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              drop;

   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      push        = 1'b0;
      push_entry  = '{last: 1'b0, data: hold_data_q};

      // eop is resolved first so a simultaneous byte lands in the freshly emptied hold.
      if (rx_endofpacket && hold_vld_q) begin
         push            = 1'b1;
         push_entry.last = 1'b1;
         hold_vld_d      = 1'b0;
      end
      if (rx_data_ready) begin
         if (hold_vld_q && !rx_endofpacket) push = 1'b1;
         hold_vld_d  = 1'b1;
         hold_data_d = rx_data;
      end
   end

   assign m_valid = !fifo_empty;
   assign m_data  = head_entry.data;
   assign m_last  = head_entry.last;
   assign pop     = m_valid && m_ready;

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (push),
      .wr_data   (push_entry),
      .wr_accept (push_accept),
      .rd_en     (pop),
      .rd_data   (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   always_comb begin
      drop       = push && !push_accept;
      overflow_d = overflow_q || drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

      pkt_cnt_d = pkt_cnt_q;
      unique case ({push_accept && push_entry.last, pop && head_entry.last})
         2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         pkt_cnt_q   <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         pkt_cnt_q   <= pkt_cnt_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign pkt_avail = (pkt_cnt_q != '0);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rx_packet_fifo.sv
// Directed bench for rx_packet_fifo: stimulus queues expected entries, a negedge monitor
// pops and compares every accepted output beat.
module tb_rx_packet_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 8;
   localparam int LVL_W  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] rx_data;
   logic              rx_data_ready;
   logic              rx_endofpacket;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_ready;
   logic [LVL_W-1:0]  level;
   logic              pkt_avail;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   rx_packet_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_data_ready  (rx_data_ready),
      .rx_endofpacket (rx_endofpacket),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_last         (m_last),
      .m_ready        (m_ready),
      .level          (level),
      .pkt_avail      (pkt_avail),
      .overflow       (overflow),
      .drop_cnt       (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic dr, input logic [7:0] d, input logic eop);
      rx_data_ready  = dr;
      rx_data        = d;
      rx_endofpacket = eop;
      tick();
      rx_data_ready  = 1'b0;
      rx_data        = '0;
      rx_endofpacket = 1'b0;
   endtask

   task automatic expect_entry(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic drain(input string name);
      m_ready = 1'b1;
      for (int i = 0; i < 64 && level != 0; i++) tick();
      m_ready = 1'b0;
      check({name, " drained level"}, 32'(level), 0);
   endtask

   // Scoreboard monitor: a beat is transferred on the next posedge when m_valid & m_ready.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected beat: got data 0x%0h last %0b, expected none", m_data, m_last);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("beat {last,data}", 32'({m_last, m_data}), 32'(e));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst            = 1'b1;
      rx_data        = '0;
      rx_data_ready  = 1'b0;
      rx_endofpacket = 1'b0;
      m_ready        = 1'b0;
      repeat (2) tick();
      check("reset m_valid",   32'(m_valid), 0);
      check("reset level",     32'(level), 0);
      check("reset pkt_avail", 32'(pkt_avail), 0);
      check("reset overflow",  32'(overflow), 0);
      check("reset drop_cnt",  32'(drop_cnt), 0);
      rst = 1'b0;
      tick();

      // eop with nothing held is ignored.
      strobe(1'b0, 8'h00, 1'b1);
      check("t4 level",     32'(level), 0);
      check("t4 pkt_avail", 32'(pkt_avail), 0);
      check("t4 m_valid",   32'(m_valid), 0);

      // Three spaced bytes then eop.
      strobe(1'b1, 8'h41, 1'b0);
      repeat (15) tick();
      strobe(1'b1, 8'h42, 1'b0);
      expect_entry(8'h41, 1'b0);
      repeat (15) tick();
      strobe(1'b1, 8'h43, 1'b0);
      expect_entry(8'h42, 1'b0);
      repeat (15) tick();
      check("t1 level before eop",     32'(level), 2);
      check("t1 pkt_avail before eop", 32'(pkt_avail), 0);
      strobe(1'b0, 8'h00, 1'b1);
      expect_entry(8'h43, 1'b1);
      check("t1 level after eop",     32'(level), 3);
      check("t1 pkt_avail after eop", 32'(pkt_avail), 1);
      drain("t1");
      check("t1 pkt_avail drained", 32'(pkt_avail), 0);

      // 18 strobes give 17 data pushes: 1..16 fit, 17 drops, then the eop push of 18 drops.
      for (int i = 1; i <= 18; i++) begin
         strobe(1'b1, 8'(i), 1'b0);
         if (i >= 2 && i <= 17) expect_entry(8'(i - 1), 1'b0);
      end
      check("t2 drop_cnt after data", 32'(drop_cnt), 1);
      strobe(1'b0, 8'h00, 1'b1);
      check("t2 level",     32'(level), 16);
      check("t2 overflow",  32'(overflow), 1);
      check("t2 drop_cnt",  32'(drop_cnt), 2);
      check("t2 pkt_avail", 32'(pkt_avail), 0);

      // Full FIFO with consumer ready: push every cycle, nothing dropped.
      strobe(1'b1, 8'h80, 1'b0);
      check("t3 level hold load", 32'(level), 16);
      m_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         strobe(1'b1, 8'(8'h80 + k), 1'b0);
         expect_entry(8'(8'h80 + k - 1), 1'b0);
         check("t3 level steady", 32'(level), 16);
      end
      strobe(1'b0, 8'h00, 1'b1);
      expect_entry(8'h88, 1'b1);
      check("t3 level after eop", 32'(level), 16);
      check("t3 drop_cnt",        32'(drop_cnt), 2);
      check("t3 pkt_avail",       32'(pkt_avail), 1);
      drain("t3");
      check("t3 overflow sticky", 32'(overflow), 1);

      // Byte and eop in the same cycle with 0x10 held.
      strobe(1'b1, 8'h10, 1'b0);
      strobe(1'b1, 8'h55, 1'b1);
      expect_entry(8'h10, 1'b1);
      check("t5 level",     32'(level), 1);
      check("t5 pkt_avail", 32'(pkt_avail), 1);
      strobe(1'b0, 8'h00, 1'b1);
      expect_entry(8'h55, 1'b1);
      check("t5 level two pkts", 32'(level), 2);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("t5 level after pop1",     32'(level), 1);
      check("t5 pkt_avail after pop1", 32'(pkt_avail), 1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("t5 level after pop2",     32'(level), 0);
      check("t5 pkt_avail after pop2", 32'(pkt_avail), 0);

      // Reset mid-packet discards buffered and held bytes.
      for (int i = 0; i < 6; i++) strobe(1'b1, 8'(8'hA0 + i), 1'b0);
      check("t6 level before rst", 32'(level), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6 m_valid",   32'(m_valid), 0);
      check("t6 m_data",    32'(m_data), 0);
      check("t6 m_last",    32'(m_last), 0);
      check("t6 level",     32'(level), 0);
      check("t6 pkt_avail", 32'(pkt_avail), 0);
      check("t6 overflow",  32'(overflow), 0);
      check("t6 drop_cnt",  32'(drop_cnt), 0);
      strobe(1'b1, 8'h77, 1'b0);
      check("t6 level hold only", 32'(level), 0);
      strobe(1'b0, 8'h00, 1'b1);
      expect_entry(8'h77, 1'b1);
      check("t6 level one pkt",  32'(level), 1);
      check("t6 pkt_avail",      32'(pkt_avail), 1);
      drain("t6");
      check("scoreboard leftover", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
